// File: rtl/matrix_pkg.sv
// Shared sizes, address bounds, FSM encoding and element address decode
// for the 3x3 systolic-array operand feeder.
package matrix_pkg;

    localparam int DW_DEF      = 8;
    localparam int N           = 3;
    localparam int ADDR_MIN    = 1;
    localparam int ADDR_MAX    = 9;
    localparam int STREAM_LAST = 4;
    localparam int DRAIN_LAST  = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic       ok;
        logic [1:0] row;
        logic [1:0] col;
    } elem_loc_t;

    // Row-major 1-based element index to (row, col); out-of-range sets ok=0.
    function automatic elem_loc_t decode_addr(input logic [3:0] addr);
        elem_loc_t  loc;
        logic [3:0] idx;
        loc = '0;
        idx = addr - 4'd1;
        if (addr >= 4'(ADDR_MIN) && addr <= 4'(ADDR_MAX)) begin
            loc.ok  = 1'b1;
            loc.row = 2'(idx / 4'd3);
            loc.col = 2'(idx % 4'd3);
        end
        return loc;
    endfunction

endpackage

// File: rtl/skew_lane.sv
// One edge lane of the feeder: picks element (t - LANE) of its row/column
// vector while streaming, giving the diagonal skew the array expects.
module skew_lane
    import matrix_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int LANE = 0
) (
    input  logic [DW-1:0] elem_i [N],
    input  logic [2:0]    t_i,
    input  logic          active_i,
    output logic [DW-1:0] operand_o
);

    logic [2:0] k;
    assign k = t_i - 3'(LANE);

    always_comb begin
        operand_o = '0;
        if (active_i && t_i >= 3'(LANE) && k <= 3'd2) begin
            operand_o = elem_i[k[1:0]];
        end
    end

endmodule

// File: rtl/matrix_feeder.sv
// Stores two 3x3 operand matrices and streams them, skewed, into the west
// and north edges of a 3x3 systolic array; all outputs are registered.
module matrix_feeder
    import matrix_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en,
    input  logic          wr_sel,
    input  logic [3:0]    wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          start,
    output logic [DW-1:0] a_out0,
    output logic [DW-1:0] a_out1,
    output logic [DW-1:0] a_out2,
    output logic [DW-1:0] b_out0,
    output logic [DW-1:0] b_out1,
    output logic [DW-1:0] b_out2,
    output logic          valid,
    output logic          busy,
    output logic          done
);

    state_t        state_q, state_d;
    logic [2:0]    t_q, t_d;
    logic [DW-1:0] a_q [N][N];
    logic [DW-1:0] b_q [N][N];
    logic [DW-1:0] b_col [N][N];
    logic [DW-1:0] a_lane [N];
    logic [DW-1:0] b_lane [N];
    logic [DW-1:0] a_op_q [N];
    logic [DW-1:0] b_op_q [N];
    logic          valid_q, busy_q, done_q;
    logic          idle_ready, start_ok, wr_accept, streaming;
    elem_loc_t     loc;

    // busy_q still covers the DONE cycle's echo, so the block only reopens once busy drops.
    assign idle_ready = (state_q == ST_IDLE) && !busy_q;
    assign start_ok   = idle_ready && start;
    assign loc        = decode_addr(wr_addr);
    assign wr_accept  = idle_ready && wr_en && !start && loc.ok;
    assign streaming  = (state_q == ST_STREAM);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
            state_q <= state_d;
            t_q     <= t_d;
        end
    end

    always_comb begin
        state_d = state_q;
        t_d     = t_q + 3'd1;
        case (state_q)
            ST_IDLE: begin
                t_d = '0;
                if (start_ok) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (t_q == 3'(STREAM_LAST)) begin
                    state_d = ST_DRAIN;
                    t_d     = '0;
                end
            end
            ST_DRAIN: begin
                if (t_q == 3'(DRAIN_LAST)) begin
                    state_d = ST_DONE;
                    t_d     = '0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                t_d     = '0;
            end
            default: begin
                state_d = ST_IDLE;
                t_d     = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the matrices are register arrays, not RAM, so clearing them on reset is legal and cheap.
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_q[r][c] <= '0;
                    b_q[r][c] <= '0;
                end
            end
        end else if (wr_accept) begin
            if (wr_sel) b_q[loc.row][loc.col] <= wr_data;
            else        a_q[loc.row][loc.col] <= wr_data;
        end
    end

    always_comb begin
        for (int c = 0; c < N; c++) begin
            for (int r = 0; r < N; r++) begin
                b_col[c][r] = b_q[r][c];
            end
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_lane
        skew_lane #(.DW(DW), .LANE(i)) u_row (
            .elem_i    (a_q[i]),
            .t_i       (t_q),
            .active_i  (streaming),
            .operand_o (a_lane[i])
        );
        skew_lane #(.DW(DW), .LANE(i)) u_col (
            .elem_i    (b_col[i]),
            .t_i       (t_q),
            .active_i  (streaming),
            .operand_o (b_lane[i])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_op_q  <= '{default: '0};
            b_op_q  <= '{default: '0};
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            a_op_q  <= a_lane;
            b_op_q  <= b_lane;
            valid_q <= streaming;
            busy_q  <= (state_q != ST_IDLE);
            done_q  <= (state_q == ST_DONE);
        end
    end

    assign a_out0 = a_op_q[0];
    assign a_out1 = a_op_q[1];
    assign a_out2 = a_op_q[2];
    assign b_out0 = b_op_q[0];
    assign b_out1 = b_op_q[1];
    assign b_out2 = b_op_q[2];
    assign valid  = valid_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_matrix_feeder.sv
// Directed bench for matrix_feeder: a table for the first full stream, then
// hand-written sequences for replay, start/write collision and mid-stream reset.
module tb_matrix_feeder;

    logic       clk, rst, wr_en, wr_sel, start;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic [7:0] a_out0, a_out1, a_out2, b_out0, b_out1, b_out2;
    logic       valid, busy, done;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [23:0] a;
        logic [23:0] b;
        logic        valid;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t        tbl [10];
    logic [47:0] rec [10];

    matrix_feeder #(.DW(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .start   (start),
        .a_out0  (a_out0),
        .a_out1  (a_out1),
        .a_out2  (a_out2),
        .b_out0  (b_out0),
        .b_out1  (b_out1),
        .b_out2  (b_out2),
        .valid   (valid),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [23:0] v3(input logic [7:0] x0, x1, x2);
        return {x2, x1, x0};
    endfunction

    function automatic logic [47:0] ops();
        return {a_out2, a_out1, a_out0, b_out2, b_out1, b_out0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic write_elem(input logic sel, input logic [3:0] addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = addr;
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Waits for done within a cycle budget, then one more cycle so busy has dropped.
    task automatic wait_done(input string name);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (done) seen = 1'b1;
        end
        check(name, seen, 1'b1);
        tick();
    endtask

    initial begin
        int vcnt, bcnt, dcnt, dcyc;
        logic [47:0] acc;

        tbl[0] = '{v3(1, 0, 0), v3(1, 0, 0), 1'b1, 1'b1, 1'b0};
        tbl[1] = '{v3(2, 4, 0), v3(0, 0, 0), 1'b1, 1'b1, 1'b0};
        tbl[2] = '{v3(3, 5, 7), v3(0, 1, 0), 1'b1, 1'b1, 1'b0};
        tbl[3] = '{v3(0, 6, 8), v3(0, 0, 0), 1'b1, 1'b1, 1'b0};
        tbl[4] = '{v3(0, 0, 9), v3(0, 0, 1), 1'b1, 1'b1, 1'b0};
        tbl[5] = '{v3(0, 0, 0), v3(0, 0, 0), 1'b0, 1'b1, 1'b0};
        tbl[6] = '{v3(0, 0, 0), v3(0, 0, 0), 1'b0, 1'b1, 1'b0};
        tbl[7] = '{v3(0, 0, 0), v3(0, 0, 0), 1'b0, 1'b1, 1'b0};
        tbl[8] = '{v3(0, 0, 0), v3(0, 0, 0), 1'b0, 1'b1, 1'b1};
        tbl[9] = '{v3(0, 0, 0), v3(0, 0, 0), 1'b0, 1'b0, 1'b0};

        rst = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0; start = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ops",   ops(), 48'd0);
        check("rst_valid", valid, 1'b0);
        check("rst_busy",  busy,  1'b0);
        check("rst_done",  done,  1'b0);

        for (int k = 1; k <= 9; k++) begin
            write_elem(1'b0, 4'(k), 8'(k));
            write_elem(1'b1, 4'(k), (k == 1 || k == 5 || k == 9) ? 8'd1 : 8'd0);
        end
        // Out-of-range addresses must not land anywhere; the table below proves it.
        write_elem(1'b0, 4'd0,  8'hFF);
        write_elem(1'b1, 4'd0,  8'hFF);
        write_elem(1'b0, 4'd12, 8'hFF);
        write_elem(1'b1, 4'd12, 8'hFF);
        check("idle_ops_after_writes", ops(), 48'd0);

        pulse_start();
        for (int i = 0; i < 10; i++) begin
            tick();
            check($sformatf("run1_c%0d_a", i + 1),     {a_out2, a_out1, a_out0}, tbl[i].a);
            check($sformatf("run1_c%0d_b", i + 1),     {b_out2, b_out1, b_out0}, tbl[i].b);
            check($sformatf("run1_c%0d_valid", i + 1), valid, tbl[i].valid);
            check($sformatf("run1_c%0d_busy", i + 1),  busy,  tbl[i].busy);
            check($sformatf("run1_c%0d_done", i + 1),  done,  tbl[i].done);
            rec[i] = ops();
        end

        pulse_start();
        vcnt = 0; bcnt = 0; dcnt = 0; dcyc = 0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (valid) vcnt++;
            if (busy)  bcnt++;
            if (done) begin
                dcnt++;
                dcyc = c;
            end
            if (c <= 10) check($sformatf("replay_c%0d", c), ops(), rec[c-1]);
        end
        check("count_valid",    vcnt, 5);
        check("count_busy",     bcnt, 9);
        check("count_done",     dcnt, 1);
        check("done_cycle",     dcyc, 9);

        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd1; wr_data = 8'h55;
        start = 1'b1;
        tick();
        wr_en = 1'b0;
        start = 1'b0;
        tick();
        check("collide_t0_a0", a_out0, 8'd1);
        wait_done("collide_done");

        pulse_start();
        tick();
        check("retain_t0_a0", a_out0, 8'd1);
        wait_done("retain_done");

        pulse_start();
        tick();
        tick();
        check("pre_rst_a", {a_out2, a_out1, a_out0}, v3(2, 4, 0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_ops",   ops(), 48'd0);
        check("abort_valid", valid, 1'b0);
        check("abort_busy",  busy,  1'b0);
        check("abort_done",  done,  1'b0);
        dcnt = 0;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (done) dcnt++;
        end
        check("abort_no_done", dcnt, 0);

        pulse_start();
        vcnt = 0; dcnt = 0; acc = '0;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (valid) vcnt++;
            if (done)  dcnt++;
            acc |= ops();
        end
        check("zero_run_ops",   acc,  48'd0);
        check("zero_run_valid", vcnt, 5);
        check("zero_run_done",  dcnt, 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
